// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with stall-safe pending branch,
// exception/ERET redirect and a small circular return-address stack.
// Latency: next pc registered, 1 cycle; stall holds pc, exc/eret override stall.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int                    STEP         = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  call_flag,
  input  logic                  ret_flag,
  input  logic                  exc_flag,
  input  logic                  eret_flag,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ce,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  ras_empty,
  output logic                  ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic                  ce_q;
  logic                  pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [PTR_W-1:0]      ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]      ras_cnt_q, ras_cnt_d;
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  ras_empty_w;
  logic                  ras_full_w;

  // Sequential increment wraps modulo 2^ADDR_WIDTH by construction.
  assign pc_inc      = pc_q + ADDR_WIDTH'(STEP);
  // ras_ptr_q points at the next free slot, so the top lives one below it.
  assign ras_top     = ras_mem[ras_ptr_q - 1'b1];
  assign ras_empty_w = (ras_cnt_q == '0);
  assign ras_full_w  = (ras_cnt_q == CNT_MAX);

  // Next-pc selection; priority is exc, eret, stall, pending, branch, ret, sequential.
  always_comb begin
    pc_d        = pc_q;
    epc_d       = epc_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (ce_q) begin
      if (exc_flag) begin
        epc_d      = pc_q;
        pc_d       = EXC_VECTOR;
        pend_vld_d = 1'b0;
      end else if (eret_flag) begin
        pc_d       = epc_q;
        pend_vld_d = 1'b0;
      end else if (stall) begin
        // Remember the branch so it is not lost while fetch is frozen.
        if (branch_flag) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = branch_addr;
        end
      end else if (pend_vld_q) begin
        pc_d       = pend_addr_q;
        pend_vld_d = 1'b0;
      end else if (branch_flag) begin
        pc_d = branch_addr;
        push = call_flag;
      end else if (ret_flag && !ras_empty_w) begin
        pc_d = ras_top;
        pop  = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // RAS pointer/count update; a push when full overwrites the oldest entry.
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (push) begin
      ras_ptr_d = ras_ptr_q + 1'b1;
      if (!ras_full_w) ras_cnt_d = ras_cnt_q + 1'b1;
    end else if (pop) begin
      ras_ptr_d = ras_ptr_q - 1'b1;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VECTOR;
      ce_q        <= 1'b0;
      epc_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
    end else begin
      ce_q        <= 1'b1;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
    end
  end

  // RAS storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr_q] <= pc_inc;
  end

  assign pc        = pc_q;
  assign ce        = ce_q;
  assign epc       = epc_q;
  assign ras_empty = ras_empty_w;
  assign ras_full  = ras_full_w;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_flag, call_flag, ret_flag, exc_flag, eret_flag;
  logic [31:0] branch_addr;
  logic [31:0] pc, epc;
  logic        ce, ras_empty, ras_full;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        re;
    logic        rf;
  } exp_t;

  exp_t sb[$];

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch_flag(branch_flag),
    .branch_addr(branch_addr),
    .call_flag  (call_flag),
    .ret_flag   (ret_flag),
    .exc_flag   (exc_flag),
    .eret_flag  (eret_flag),
    .pc         (pc),
    .ce         (ce),
    .epc        (epc),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] addr,
                       input logic cl, input logic rt, input logic ex, input logic er);
    stall       = st;
    branch_flag = br;
    branch_addr = addr;
    call_flag   = cl;
    ret_flag    = rt;
    exc_flag    = ex;
    eret_flag   = er;
  endtask

  // Push expectation, clock one edge, pop and compare.
  task automatic step(input logic [31:0] exp_pc, input logic re, input logic rf);
    exp_t e;
    sb.push_back('{pc: exp_pc, re: re, rf: rf});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc", pc, e.pc);
    chk("ce", {31'b0, ce}, 32'd1);
    chk("ras_empty", {31'b0, ras_empty}, {31'b0, e.re});
    chk("ras_full", {31'b0, ras_full}, {31'b0, e.rf});
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    #12;
    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", {31'b0, ce}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", {31'b0, ras_empty}, 32'd1);
    chk("rst_full", {31'b0, ras_full}, 32'd0);
    rst = 1'b1;

    // Start-up: first edge only enables fetch
    step(32'h0, 1, 0);
    step(32'h4, 1, 0);
    step(32'h8, 1, 0);
    step(32'hC, 1, 0);
    step(32'h10, 1, 0);

    // Stalled branch held pending, later stalled branch overwrites
    drive(1, 1, 32'h0BAD_0000, 0, 0, 0, 0); step(32'h10, 1, 0);
    drive(1, 1, 32'h1111_1110, 0, 0, 0, 0); step(32'h10, 1, 0);
    // Pending beats a live branch on release
    drive(0, 1, 32'h2222_2220, 0, 0, 0, 0); step(32'h1111_1110, 1, 0);
    idle();                                  step(32'h1111_1114, 1, 0);

    // Exception beats stall and discards pending
    drive(0, 1, 32'h3C, 0, 0, 0, 0);         step(32'h3C, 1, 0);
    idle();                                  step(32'h40, 1, 0);
    drive(1, 1, 32'h5555_5550, 0, 0, 0, 0);  step(32'h40, 1, 0);
    drive(1, 0, 32'h0, 0, 0, 1, 0);          step(32'h180, 1, 0);
    chk("epc_exc", epc, 32'h40);
    idle();                                  step(32'h184, 1, 0);
    drive(0, 0, 32'h0, 0, 0, 0, 1);          step(32'h40, 1, 0);
    idle();                                  step(32'h44, 1, 0);
    // exc and eret together: exception wins
    drive(0, 0, 32'h0, 0, 0, 1, 1);          step(32'h180, 1, 0);
    chk("epc_both", epc, 32'h44);
    drive(1, 0, 32'h0, 0, 0, 0, 1);          step(32'h44, 1, 0);

    // Call / return
    drive(0, 1, 32'h20, 0, 0, 0, 0);         step(32'h20, 1, 0);
    drive(0, 1, 32'h100, 1, 0, 0, 0);        step(32'h100, 0, 0);
    idle();                                  step(32'h104, 0, 0);
    drive(1, 0, 32'h0, 0, 1, 0, 0);          step(32'h104, 0, 0);
    drive(0, 0, 32'h0, 0, 1, 0, 0);          step(32'h24, 1, 0);
    idle();                                  step(32'h28, 1, 0);
    drive(0, 0, 32'h0, 0, 1, 0, 0);          step(32'h2C, 1, 0);
    drive(0, 0, 32'h0, 1, 0, 0, 0);          step(32'h30, 1, 0);

    // RAS overflow and drain
    drive(0, 1, 32'h0, 0, 0, 0, 0);          step(32'h0, 1, 0);
    drive(0, 1, 32'h100, 1, 0, 0, 0);        step(32'h100, 0, 0);
    drive(0, 1, 32'h200, 1, 0, 0, 0);        step(32'h200, 0, 0);
    drive(0, 1, 32'h300, 1, 0, 0, 0);        step(32'h300, 0, 0);
    drive(0, 1, 32'h400, 1, 0, 0, 0);        step(32'h400, 0, 1);
    drive(0, 1, 32'h500, 1, 0, 0, 0);        step(32'h500, 0, 1);
    drive(0, 0, 32'h0, 0, 1, 0, 0);          step(32'h404, 0, 0);
    step(32'h304, 0, 0);
    step(32'h204, 0, 0);
    step(32'h104, 1, 0);
    step(32'h108, 1, 0);

    // Wrap-around and asynchronous reset
    drive(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);  step(32'hFFFF_FFFC, 0, 0);
    idle();                                  step(32'h0, 0, 0);
    step(32'h4, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_ce", {31'b0, ce}, 32'd0);
    chk("arst_empty", {31'b0, ras_empty}, 32'd1);
    #1;
    rst = 1'b1;
    step(32'h0, 1, 0);
    step(32'h4, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the simplemips fetch stage, and successor to the basic PC register.
- Adds pipeline stall, a stall-safe pending branch, exception redirect with EPC capture, ERET, and a small return-address stack (RAS) for call/return.
- Drives the instruction-memory address and the fetch enable.

Parameters:
ADDR_WIDTH, 32, width of pc, branch_addr, epc.
RESET_VECTOR, 32'h00000000, pc value held in reset.
EXC_VECTOR, 32'h00000180, exception handler address.
STEP, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hold pc (fetch stalled).
branch_flag  in  1  taken branch/jump this cycle.
branch_addr  in  ADDR_WIDTH  branch target.
call_flag  in  1  branch is a call; push link address (valid only with branch_flag).
ret_flag  in  1  return; pop RAS top as target.
exc_flag  in  1  exception request.
eret_flag  in  1  return from exception to epc.
pc  out  ADDR_WIDTH  current fetch address.
ce  out  1  fetch enable.
epc  out  ADDR_WIDTH  saved exception pc.
ras_empty  out  1  RAS count==0.
ras_full  out  1  RAS count==RAS_DEPTH.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_VECTOR, ce=0, epc=0.
  - Pending-branch valid=0.
  - RAS pointer/count=0, so ras_empty=1, ras_full=0.
- First rising edge after rst release: ce←1, pc unchanged. pc advances only on edges where ce was already 1.
- Per edge with ce=1, first match wins:
  1. exc_flag: epc←pc, pc←EXC_VECTOR, pending cleared. Ignores stall.
  2. eret_flag: pc←epc, pending cleared. Ignores stall.
  3. stall=1: pc held.
     - If branch_flag, the pending register ←branch_addr (valid=1). A later stalled branch overwrites it.
     - call_flag and ret_flag are ignored while stalled; the issuer holds them until stall=0.
  4. Pending valid: pc←pending addr, valid←0. Any live branch_flag/ret_flag this edge is ignored.
  5. branch_flag: pc←branch_addr. If call_flag is also set, push pc+STEP.
  6. ret_flag with RAS non-empty: pc←top, pop.
  7. ret_flag with RAS empty: treated as no ret; pc←pc+STEP.
  8. Otherwise: pc←pc+STEP.
- Arithmetic: pc+STEP is computed modulo 2^ADDR_WIDTH; 0xFFFFFFFC+4 → 0x00000000. branch_addr is used unmodified (no alignment forcing).
- RAS: circular buffer.
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH.
  - Pop decrements count and pointer.
  - call_flag without branch_flag: no push, no effect.
  - Exceptions and ERET leave the RAS untouched.
- Simultaneous exc_flag and eret_flag: exception wins, and epc takes the current pc.
- Reset mid-operation clears the RAS and pending state immediately; pc shows RESET_VECTOR in the same cycle.
- All outputs are registered; next-pc latency is 1 cycle.

Test Plan:
- Reset/start: rst=0 → pc=0, ce=0. Release rst. Edge 1: ce=1, pc=0. Edges 2,3: pc=4, 8.
- Stalled branch: at pc=0x10, stall=1 and branch_flag=1 with addr 0x11111110 for 2 edges → pc stays 0x10. Drop stall → next edge pc=0x11111110, then 0x11111114.
- Exception beats stall: pc=0x40, stall=1, exc_flag=1 → pc=0x180, epc=0x40. Pending branch discarded. eret_flag next → pc=0x40.
- Call/return: at pc=0x20, branch_flag+call_flag to 0x100 → pc=0x100, ras_empty=0. Later ret_flag → pc=0x24, ras_empty=1. A further ret_flag at pc=0x28 → pc=0x2C.
- RAS overflow: 5 calls from pc 0x0,0x100,0x200,0x300,0x400 (DEPTH=4) → ras_full=1. 4 rets yield 0x404, 0x304, 0x204, 0x104, then ras_empty=1.
- Wrap and async reset: branch to 0xFFFFFFFC → next pc=0x00000000. Assert rst low between edges → pc=0 and ce=0 immediately, without waiting for an edge.
